game_ui_sequencer: RTL and testbench

Runtime controller directly upstream of the UI ROM reader. It owns the millisecond game clock (current_time) and the UI ROM address, and runs the update_ui_time / sync_ui_time handshake. Each entry stays in force until current_time reaches the entry's next_ui_time; the sequencer then advances the address and releases the reader to fetch the next entry. It stops on the end-of-table marker (is_end).

---
 rtl/game_ui_pkg.sv | 15 +
 rtl/game_tick_timer.sv | 59 +++++
 rtl/game_ui_sequencer.sv | 143 ++++++++++++++
 tb/tb_game_ui_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_ui_pkg.sv
// Shared definitions for the UI sequencer, its tick timer and the UI ROM reader.
package game_ui_pkg;

    typedef enum logic [1:0] {
        ST_PRIME = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } ui_state_e;

    localparam int UI_ADDR_WIDTH    = 10;
    localparam int UI_MAXIMUM_TIMES = 30;
    localparam int UI_TICK_DIV      = 25000;

endpackage

// File: rtl/game_tick_timer.sv
// Prescaled game timebase: one current_time increment every TICK_DIV enabled
// clocks, saturating at all-ones.
module game_tick_timer
    import game_ui_pkg::*;
#(
    parameter int MAXIMUM_TIMES = UI_MAXIMUM_TIMES,
    parameter int TICK_DIV      = UI_TICK_DIV
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     enable,
    output logic [MAXIMUM_TIMES-1:0] current_time
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [MAXIMUM_TIMES-1:0] TIME_MAX = {MAXIMUM_TIMES{1'b1}};

    logic [PW-1:0]            presc_q, presc_d;
    logic [MAXIMUM_TIMES-1:0] time_q, time_d;

    // Next-state for prescaler and saturating time counter.
    always_comb begin
        presc_d = presc_q;
        time_d  = time_q;
        if (clear) begin
            presc_d = {PW{1'b0}};
            time_d  = {MAXIMUM_TIMES{1'b0}};
        end else if (enable) begin
            if (presc_q == PRE_LAST) begin
                presc_d = {PW{1'b0}};
                if (time_q != TIME_MAX) begin
                    time_d = time_q + MAXIMUM_TIMES'(1);
                end else begin
                    time_d = time_q;
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end else begin
            presc_d = presc_q;
        end
    end

    // Timebase registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= {PW{1'b0}};
            time_q  <= {MAXIMUM_TIMES{1'b0}};
        end else begin
            presc_q <= presc_d;
            time_q  <= time_d;
        end
    end

    assign current_time = time_q;

endmodule

// File: rtl/game_ui_sequencer.sv
// UI table sequencer: owns the game clock and the UI ROM address, and paces
// the reader through the table with the update/sync handshake.
module game_ui_sequencer
    import game_ui_pkg::*;
#(
    parameter int ADDR_WIDTH    = UI_ADDR_WIDTH,
    parameter int MAXIMUM_TIMES = UI_MAXIMUM_TIMES,
    parameter int TICK_DIV      = UI_TICK_DIV
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     pause,
    input  logic                     restart,
    input  logic                     update_ui_time,
    input  logic [MAXIMUM_TIMES-1:0] next_ui_time,
    input  logic                     is_end,
    output logic [ADDR_WIDTH-1:0]    addr,
    output logic [MAXIMUM_TIMES-1:0] current_time,
    output logic                     sync_ui_time,
    output logic                     ui_event,
    output logic                     done
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};

    ui_state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [MAXIMUM_TIMES-1:0] next_q, next_d;
    logic                     sync_q, sync_d;
    logic                     ui_event_q, ui_event_d;
    logic                     done_q, done_d;
    logic [MAXIMUM_TIMES-1:0] time_s;
    logic                     time_en_s;
    logic                     expired_s;

    // Time is held in PRIME so the game clock starts with the first entry.
    assign time_en_s = (state_q != ST_PRIME) && !pause;
    assign expired_s = (time_s >= next_q);

    game_tick_timer #(
        .MAXIMUM_TIMES (MAXIMUM_TIMES),
        .TICK_DIV      (TICK_DIV)
    ) u_tick_timer (
        .clk          (clk),
        .reset        (reset),
        .clear        (restart),
        .enable       (time_en_s),
        .current_time (time_s)
    );

    // Sequencer next-state; restart overrides every transition.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        next_d     = next_q;
        sync_d     = sync_q;
        done_d     = done_q;
        ui_event_d = 1'b0;
        if (restart) begin
            state_d = ST_PRIME;
            addr_d  = {ADDR_WIDTH{1'b0}};
            sync_d  = 1'b1;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                ST_PRIME: begin
                    if (start) begin
                        state_d = ST_LOAD;
                        sync_d  = 1'b0;
                    end else begin
                        sync_d  = 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (update_ui_time) begin
                        next_d = next_ui_time;
                        sync_d = 1'b1;
                        if (is_end) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d    = ST_WAIT;
                            ui_event_d = 1'b1;
                        end
                    end else begin
                        sync_d = 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (expired_s) begin
                        // Last address cannot advance: treat as end of table.
                        if (addr_q == ADDR_LAST) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            addr_d  = addr_q + ADDR_WIDTH'(1);
                            state_d = ST_LOAD;
                            sync_d  = 1'b0;
                        end
                    end else begin
                        sync_d = 1'b1;
                    end
                end
                ST_DONE: begin
                    sync_d = 1'b1;
                    done_d = 1'b1;
                end
                default: begin
                    state_d = ST_PRIME;
                    sync_d  = 1'b1;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_PRIME;
            addr_q     <= {ADDR_WIDTH{1'b0}};
            next_q     <= {MAXIMUM_TIMES{1'b0}};
            sync_q     <= 1'b1;
            ui_event_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            next_q     <= next_d;
            sync_q     <= sync_d;
            ui_event_q <= ui_event_d;
            done_q     <= done_d;
        end
    end

    assign addr         = addr_q;
    assign current_time = time_s;
    assign sync_ui_time = sync_q;
    assign ui_event     = ui_event_q;
    assign done         = done_q;

endmodule

// File: tb/tb_game_ui_sequencer.sv
// Bench for game_ui_sequencer: two instances (full size and a tiny one for
// saturation/overflow) checked every cycle against a behavioural model.
module tb_game_ui_sequencer;

    localparam int P_IDLE  = 0;
    localparam int P_FETCH = 1;
    localparam int P_HOLD  = 2;
    localparam int P_FIN   = 3;

    localparam longint A_TD    = 64'd4;
    localparam longint A_MAXCT = 64'd1073741823;
    localparam longint A_MAXAD = 64'd1023;
    localparam longint B_TD    = 64'd2;
    localparam longint B_MAXCT = 64'd63;
    localparam longint B_MAXAD = 64'd3;

    typedef struct {
        int     phase;
        longint addr;
        longint nxt;
        longint en;
        bit     sync;
        bit     ev;
        bit     done;
    } mstate_t;

    logic        clk;
    logic        reset, start, pause, restart;
    logic        upd_a, end_a, upd_b, end_b;
    logic [29:0] nxt_a;
    logic [5:0]  nxt_b;
    logic [9:0]  addr_a;
    logic [29:0] ct_a;
    logic [1:0]  addr_b;
    logic [5:0]  ct_b;
    logic        sync_a, ev_a, done_a, sync_b, ev_b, done_b;

    int errors = 0;
    int checks = 0;
    int mode = 0;
    int lat_a = 1, cnt_a = 0, lat_b = 1, cnt_b = 0;
    int ev_cnt_a = 0;
    bit hit;
    mstate_t ma, mb;

    game_ui_sequencer #(.ADDR_WIDTH(10), .MAXIMUM_TIMES(30), .TICK_DIV(4)) dut_a (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .restart(restart),
        .update_ui_time(upd_a), .next_ui_time(nxt_a), .is_end(end_a),
        .addr(addr_a), .current_time(ct_a), .sync_ui_time(sync_a),
        .ui_event(ev_a), .done(done_a)
    );

    game_ui_sequencer #(.ADDR_WIDTH(2), .MAXIMUM_TIMES(6), .TICK_DIV(2)) dut_b (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .restart(restart),
        .update_ui_time(upd_b), .next_ui_time(nxt_b), .is_end(end_b),
        .addr(addr_b), .current_time(ct_b), .sync_ui_time(sync_b),
        .ui_event(ev_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Game time = whole ticks elapsed over all enabled clocks, clamped.
    function automatic longint ctof(mstate_t s, longint td, longint maxct);
        longint t;
        t = s.en / td;
        return (t > maxct) ? maxct : t;
    endfunction

    function automatic mstate_t mstep(mstate_t s, bit rst, bit rs, bit st, bit pz,
                                      bit up, longint nx, bit ie,
                                      longint td, longint maxct, longint maxad);
        mstate_t n;
        longint  ct;
        n    = s;
        n.ev = 1'b0;
        ct   = ctof(s, td, maxct);
        if (rst || rs) begin
            n.phase = P_IDLE; n.addr = 0; n.en = 0; n.sync = 1'b1; n.done = 1'b0;
            return n;
        end
        if (s.phase != P_IDLE && !pz) n.en = s.en + 1;
        case (s.phase)
            P_IDLE:  if (st) begin n.phase = P_FETCH; n.sync = 1'b0; end
            P_FETCH: if (up) begin
                         n.nxt = nx; n.sync = 1'b1;
                         if (ie) begin n.phase = P_FIN; n.done = 1'b1; end
                         else begin n.phase = P_HOLD; n.ev = 1'b1; end
                     end
            P_HOLD:  if (ct >= s.nxt) begin
                         if (s.addr == maxad) begin n.phase = P_FIN; n.done = 1'b1; end
                         else begin n.addr = s.addr + 1; n.phase = P_FETCH; n.sync = 1'b0; end
                     end
            default: ;
        endcase
        return n;
    endfunction

    function automatic mstate_t minit();
        mstate_t n;
        n.phase = P_IDLE; n.addr = 0; n.nxt = 0; n.en = 0;
        n.sync = 1'b1; n.ev = 1'b0; n.done = 1'b0;
        return n;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reader models: answer after lat cycles of sync low, junk pulses otherwise.
    task automatic reader_drive();
        longint v;
        if (!ma.sync) begin
            upd_a = (cnt_a == lat_a);
            end_a = 1'b0;
            case (mode)
                0: begin
                    v = (ma.addr == 0) ? 10 : 0;
                    end_a = (ma.addr >= 2);
                end
                1: begin
                    v = (ma.addr == 0) ? 20 : ((ma.addr == 5) ? ctof(ma, A_TD, A_MAXCT) + 3 : 0);
                    end_a = (ma.addr >= 6);
                end
                default: begin
                    v = ctof(ma, A_TD, A_MAXCT) + longint'($urandom_range(0, 6));
                    end_a = ($urandom_range(0, 7) == 0);
                end
            endcase
            nxt_a = 30'(v);
            cnt_a++;
        end else begin
            cnt_a = 0;
            lat_a = (mode == 2) ? int'($urandom_range(0, 3)) : 1;
            upd_a = ($urandom_range(0, 3) == 0);
            end_a = ($urandom_range(0, 1) == 0);
            nxt_a = 30'($urandom);
        end
        if (!mb.sync) begin
            upd_b = (cnt_b == lat_b);
            end_b = 1'b0;
            v = (mb.addr + 1) * 20;
            nxt_b = 6'((v > 63) ? 63 : v);
            cnt_b++;
        end else begin
            cnt_b = 0;
            lat_b = int'($urandom_range(0, 2));
            upd_b = ($urandom_range(0, 3) == 0);
            end_b = ($urandom_range(0, 1) == 0);
            nxt_b = 6'($urandom);
        end
    endtask

    task automatic do_cycle();
        @(negedge clk);
        reader_drive();
        @(posedge clk);
        ma = mstep(ma, reset, restart, start, pause, upd_a, longint'(nxt_a), end_a, A_TD, A_MAXCT, A_MAXAD);
        mb = mstep(mb, reset, restart, start, pause, upd_b, longint'(nxt_b), end_b, B_TD, B_MAXCT, B_MAXAD);
        #1;
        if (ev_a === 1'b1) ev_cnt_a++;
        check("a_addr", 64'(addr_a), 64'(ma.addr));
        check("a_time", 64'(ct_a), 64'(ctof(ma, A_TD, A_MAXCT)));
        check("a_sync", 64'(sync_a), 64'(ma.sync));
        check("a_event", 64'(ev_a), 64'(ma.ev));
        check("a_done", 64'(done_a), 64'(ma.done));
        check("b_addr", 64'(addr_b), 64'(mb.addr));
        check("b_time", 64'(ct_b), 64'(ctof(mb, B_TD, B_MAXCT)));
        check("b_sync", 64'(sync_b), 64'(mb.sync));
        check("b_event", 64'(ev_b), 64'(mb.ev));
        check("b_done", 64'(done_b), 64'(mb.done));
    endtask

    initial begin
        ma = minit(); mb = minit();
        reset = 1'b1; start = 1'b0; pause = 1'b0; restart = 1'b0;
        upd_a = 1'b0; end_a = 1'b0; nxt_a = 30'd0;
        upd_b = 1'b0; end_b = 1'b0; nxt_b = 6'd0;

        // Startup: three reset cycles, then run the short directed table.
        for (int i = 0; i < 3; i++) do_cycle();
        reset = 1'b0; start = 1'b1; mode = 0;
        ev_cnt_a = 0;
        hit = 1'b0;
        for (int i = 0; i < 300 && !ma.done; i++) begin
            do_cycle();
            if (!hit && addr_a === 10'd1) begin
                hit = 1'b1;
                check("a_expiry_time", 64'(ct_a), 64'd10);
            end
        end
        check("a_end_done", 64'(done_a), 64'd1);
        check("a_end_addr", 64'(addr_a), 64'd2);
        check("a_end_events", 64'(ev_cnt_a), 64'd2);
        for (int i = 0; i < 12; i++) do_cycle();
        check("a_end_hold_addr", 64'(addr_a), 64'd2);

        // Restart, then pause for 100 cycles inside the first WAIT.
        restart = 1'b1; mode = 1;
        do_cycle();
        restart = 1'b0;
        check("a_restart_addr", 64'(addr_a), 64'd0);
        check("a_restart_time", 64'(ct_a), 64'd0);
        for (int i = 0; i < 50 && ma.phase != P_HOLD; i++) do_cycle();
        pause = 1'b1;
        for (int i = 0; i < 100; i++) do_cycle();
        pause = 1'b0;

        // Restart colliding with the WAIT expiry at address 5.
        hit = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (ma.phase == P_HOLD && ma.addr == 5 && ctof(ma, A_TD, A_MAXCT) >= ma.nxt) begin
                hit = 1'b1;
                break;
            end
            do_cycle();
        end
        check("a_collide_reached", 64'(addr_a), 64'(hit ? 5 : 999));
        restart = 1'b1;
        do_cycle();
        restart = 1'b0;
        check("a_collide_addr", 64'(addr_a), 64'd0);
        check("a_collide_time", 64'(ct_a), 64'd0);
        check("a_collide_done", 64'(done_a), 64'd0);
        check("a_collide_sync", 64'(sync_a), 64'd1);

        // Let the tiny instance saturate its clock and overflow its address.
        mode = 0;
        for (int i = 0; i < 220; i++) do_cycle();
        check("b_sat_time", 64'(ct_b), 64'd63);
        check("b_ovf_addr", 64'(addr_b), 64'd3);
        check("b_ovf_done", 64'(done_b), 64'd1);

        // Randomized run: pauses, start toggles, occasional restarts.
        mode = 2;
        restart = 1'b1;
        do_cycle();
        for (int i = 0; i < 800; i++) begin
            restart = ($urandom_range(0, 60) == 0);
            pause   = ($urandom_range(0, 5) == 0);
            start   = ($urandom_range(0, 3) != 0);
            do_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
